// File: rtl/zpu_mem_bridge.sv
// zpu_mem_bridge: bridges the zpu_core read/write/done handshake to a word RAM
// and a small I/O register page (console byte out, status, cycle counter, exit).
// One access in flight at a time; o_done pulses for one cycle to complete it.
// Optional feature: define BUS_TIMEOUT_EN to abort RAM accesses that receive no
// i_ram_done within TIMEOUT cycles (sets sticky o_bus_error, returns 32'hDEADBEEF).
module zpu_mem_bridge #(
  parameter int unsigned AW      = 20,
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_read,
  input  logic          i_write,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_data_write,
  output logic [31:0]   o_data_read,
  output logic          o_done,
  output logic          o_ram_read,
  output logic          o_ram_write,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_data_write,
  input  logic [31:0]   i_ram_data_read,
  input  logic          i_ram_done,
  output logic          o_tx_valid,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_ready,
  output logic          o_halt,
  output logic [7:0]    o_exit_code,
  output logic          o_bus_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAM,
    S_TX,
    S_DONE
  } state_t;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_EXIT   = 2'd3;

  state_t        state, state_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [31:0]   rdata_q;
  logic [7:0]    tx_byte;
  logic          halt;
  logic [7:0]    exit_code;
  logic [31:0]   cyc;
  logic          bus_err;
  logic          ram_tmo;

  logic       req;
  logic       io_hit;
  logic [1:0] io_off;

  assign req    = i_read | i_write;
  assign io_hit = (i_addr[31:4] == IO_BASE[31:4]);
  assign io_off = i_addr[3:2];

`ifdef BUS_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // RAM wait counter: cleared outside RAM, counts each cycle spent waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == S_RAM) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign ram_tmo = (state == S_RAM) && !i_ram_done && (tmo_cnt == 32'(TIMEOUT));
`else
  logic [31:0] tmo_unused;
  assign tmo_unused = 32'(TIMEOUT);
  assign ram_tmo    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; a simultaneous read+write is taken as a write
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (i_write) begin
          if (!io_hit)                  state_d = S_RAM;
          else if (io_off == OFF_DATA)  state_d = S_TX;
          else                          state_d = S_DONE;
        end else if (i_read) begin
          state_d = io_hit ? S_DONE : S_RAM;
        end
      end
      S_RAM:  if (i_ram_done || ram_tmo) state_d = S_DONE;
      S_TX:   if (i_tx_ready)            state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request latching, I/O register effects, read data capture, cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      tx_byte   <= '0;
      halt      <= 1'b0;
      exit_code <= '0;
      cyc       <= '0;
      bus_err   <= 1'b0;
    end else begin
      cyc <= cyc + 32'd1;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= i_addr[AW-1:0];
            wdata_q <= i_data_write;
            wr_q    <= i_write;
            rdata_q <= '0;
            if (io_hit) begin
              if (i_write) begin
                if (io_off == OFF_DATA) tx_byte <= i_data_write[7:0];
                if (io_off == OFF_EXIT && !halt) begin
                  halt      <= 1'b1;
                  exit_code <= i_data_write[7:0];
                end
              end else begin
                unique case (io_off)
                  OFF_DATA:   rdata_q <= '0;
                  OFF_STATUS: rdata_q <= {30'b0, halt, 1'b0};
                  OFF_CYCLE:  rdata_q <= cyc;
                  OFF_EXIT:   rdata_q <= {24'b0, exit_code};
                  default:    rdata_q <= '0;
                endcase
              end
            end
          end
        end
        S_RAM: begin
          if (i_ram_done) begin
            rdata_q <= i_ram_data_read;
          end else if (ram_tmo) begin
            rdata_q <= 32'hDEAD_BEEF;
            bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and latched access
  always_comb begin
    o_done           = (state == S_DONE);
    o_data_read      = (state == S_DONE) ? rdata_q : '0;
    o_ram_read       = (state == S_RAM) && !wr_q;
    o_ram_write      = (state == S_RAM) &&  wr_q;
    o_ram_addr       = addr_q;
    o_ram_data_write = wdata_q;
    o_tx_valid       = (state == S_TX);
    o_tx_data        = tx_byte;
    o_halt           = halt;
    o_exit_code      = exit_code;
    o_bus_error      = bus_err;
  end

endmodule

// File: tb/tb_zpu_mem_bridge.sv
// Self-checking bench for zpu_mem_bridge: randomized CPU accesses against a
// transaction-level reference (word memory, cycle count, console byte queue).
module tb_zpu_mem_bridge;

  localparam int unsigned AW      = 20;
  localparam logic [31:0] IO_BASE = 32'h8000_0000;
  localparam int unsigned TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_read = 1'b0;
  logic          i_write = 1'b0;
  logic [31:0]   i_addr = '0;
  logic [31:0]   i_data_write = '0;
  logic [31:0]   o_data_read;
  logic          o_done;
  logic          o_ram_read;
  logic          o_ram_write;
  logic [AW-1:0] o_ram_addr;
  logic [31:0]   o_ram_data_write;
  logic [31:0]   i_ram_data_read = '0;
  logic          i_ram_done = 1'b0;
  logic          o_tx_valid;
  logic [7:0]    o_tx_data;
  logic          i_tx_ready = 1'b1;
  logic          o_halt;
  logic [7:0]    o_exit_code;
  logic          o_bus_error;

  int tests = 0;
  int fails = 0;

  zpu_mem_bridge #(.AW(AW), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_data_write(i_data_write),
    .o_data_read(o_data_read), .o_done(o_done),
    .o_ram_read(o_ram_read), .o_ram_write(o_ram_write), .o_ram_addr(o_ram_addr),
    .o_ram_data_write(o_ram_data_write), .i_ram_data_read(i_ram_data_read),
    .i_ram_done(i_ram_done),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_halt(o_halt), .o_exit_code(o_exit_code), .o_bus_error(o_bus_error)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: the value the cycle register holds at any edge
  int unsigned tb_edges = 0;
  always @(posedge clk) begin
    if (!reset) tb_edges <= 0;
    else        tb_edges <= tb_edges + 1;
  end

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // RAM device: responds ram_lat_cfg cycles after it first sees a strobe
  logic [31:0] ram_mem [logic [AW-1:0]];
  int  ram_lat_cfg = 0;
  bit  ram_silent = 0;
  bit  ram_pend = 0;
  int  ram_cnt = 0;
  always @(negedge clk) begin
    i_ram_done = 1'b0;
    if (!reset) begin
      ram_pend = 0;
    end else if ((o_ram_read || o_ram_write) && !ram_silent) begin
      if (!ram_pend) begin
        ram_pend = 1;
        ram_cnt  = ram_lat_cfg;
      end
      if (ram_cnt == 0) begin
        i_ram_done = 1'b1;
        ram_pend   = 0;
        if (o_ram_write) ram_mem[o_ram_addr] = o_ram_data_write;
        i_ram_data_read = ram_mem.exists(o_ram_addr) ? ram_mem[o_ram_addr] : init_word(o_ram_addr);
      end else begin
        ram_cnt--;
      end
    end
  end

  // Console sink: records every accepted byte
  logic [7:0] tx_log[$];
  logic [7:0] exp_tx[$];
  always @(negedge clk) begin
    if (reset && o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
  end

  // Reference state
  logic [31:0] ref_mem [logic [AW-1:0]];
  bit          halt_m = 0;
  logic [7:0]  code_m = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // One CPU access; returns read data and the edge count until o_done was seen
  task automatic cpu_access(input bit wr, input bit both, input logic [31:0] addr,
                            input logic [31:0] data, input int lat,
                            output logic [31:0] rd, output int edges);
    ram_lat_cfg  = lat;
    i_addr       = addr;
    i_data_write = data;
    i_write      = wr;
    i_read       = !wr || both;
    edges        = 0;
    rd           = 'x;
    while (edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (o_done) begin
        rd = o_data_read;
        break;
      end
    end
    i_read  = 1'b0;
    i_write = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width addr=%h: o_done=%b, required 0", addr, o_done);
    end
  endtask

  task automatic check_tx_log(input string name);
    tests++;
    if (tx_log.size() != exp_tx.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, tx_log.size(), exp_tx.size());
    end else begin
      foreach (exp_tx[i]) begin
        tests++;
        if (tx_log[i] !== exp_tx[i]) begin
          fails++;
          $display("FAIL %s_byte%0d: got %h, required %h", name, i, tx_log[i], exp_tx[i]);
        end
      end
    end
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_done, o_ram_read, o_ram_write, o_tx_valid, o_halt, o_bus_error} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 000000",
               {o_done, o_ram_read, o_ram_write, o_tx_valid, o_halt, o_bus_error});
    end
    tests++;
    if ({o_data_read, o_exit_code, o_tx_data} !== 48'h0) begin
      fails++;
      $display("FAIL reset_data: got %h, required 0", {o_data_read, o_exit_code, o_tx_data});
    end
    tests++;
    if ({o_ram_addr, o_ram_data_write} !== '0) begin
      fails++;
      $display("FAIL reset_ram_bus: got %h, required 0", {o_ram_addr, o_ram_data_write});
    end
    reset = 1'b1;
  endtask

  task automatic test_ram_read();
    logic [31:0] rd;
    int ed;
    ram_mem[20'h100] = 32'h1234_5678;
    ref_mem[20'h100] = 32'h1234_5678;
    cpu_access(0, 0, 32'h0000_0100, 32'h0, 3, rd, ed);
    tests++;
    if (rd !== 32'h1234_5678) begin
      fails++;
      $display("FAIL ram_read_data: got %h, required 12345678", rd);
    end
    tests++;
    if (ed != 5) begin
      fails++;
      $display("FAIL ram_read_latency: got %0d edges, required 5", ed);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, data, exp;
    int ed, exp_ed, lat, kind;
    bit wr, both;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      data = $urandom;
      if (kind <= 5) begin
        addr = ($urandom & 32'h7FF0_0000) | (32'($urandom_range(0, 15)) << 2);
        lat  = $urandom_range(0, 4);
        wr   = 1'($urandom_range(0, 1));
        both = 1'($urandom_range(0, 1));
        exp  = ref_read(addr);
        exp_ed = lat + 2;
        cpu_access(wr, both, addr, data, lat, rd, ed);
        if (wr) begin
          ref_mem[addr[AW-1:0]] = data;
        end else begin
          tests++;
          if (rd !== exp) begin
            fails++;
            $display("FAIL rand_ram_read%0d addr=%h: got %h, required %h", i, addr, rd, exp);
          end
        end
      end else begin
        unique case (kind)
          6: begin addr = IO_BASE + 32'd8;  wr = 0; exp = 32'(tb_edges);     exp_ed = 1; end
          7: begin addr = IO_BASE + 32'd4;  wr = 0; exp = {30'b0, halt_m, 1'b0}; exp_ed = 1; end
          8: begin addr = IO_BASE;          wr = 1; exp = 32'h0;             exp_ed = 2; end
          default: begin addr = IO_BASE;    wr = 0; exp = 32'h0;             exp_ed = 1; end
        endcase
        if (kind == 8) exp_tx.push_back(data[7:0]);
        cpu_access(wr, 0, addr, data, 0, rd, ed);
        if (!wr) begin
          tests++;
          if (rd !== exp) begin
            fails++;
            $display("FAIL rand_io_read%0d addr=%h: got %h, required %h", i, addr, rd, exp);
          end
        end
      end
      tests++;
      if (ed != exp_ed) begin
        fails++;
        $display("FAIL rand_latency%0d addr=%h: got %0d edges, required %0d", i, addr, ed, exp_ed);
      end
    end
    check_tx_log("rand_tx");
  endtask

  task automatic test_console();
    i_tx_ready   = 1'b0;
    i_addr       = IO_BASE;
    i_data_write = 32'h0000_AB41;
    i_write      = 1'b1;
    exp_tx.push_back(8'h41);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      tests++;
      if ({o_tx_valid, o_tx_data, o_done} !== {1'b1, 8'h41, 1'b0}) begin
        fails++;
        $display("FAIL tx_stall%0d: valid/data/done=%b/%h/%b, required 1/41/0",
                 k, o_tx_valid, o_tx_data, o_done);
      end
    end
    i_tx_ready = 1'b1;
    @(posedge clk); #1;
    i_write = 1'b0;
    tests++;
    if ({o_done, o_tx_valid} !== 2'b10) begin
      fails++;
      $display("FAIL tx_done: done/valid=%b/%b, required 1/0", o_done, o_tx_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL tx_done_width: o_done=%b, required 0", o_done);
    end
    check_tx_log("console");
  endtask

  task automatic test_cycle();
    logic [31:0] r1, r2;
    int ed;
    int unsigned a;
    int guard;
    a = tb_edges;
    cpu_access(0, 0, IO_BASE + 32'd8, 32'h0, 0, r1, ed);
    guard = 0;
    while (tb_edges != a + 10 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    cpu_access(0, 0, IO_BASE + 32'd8, 32'h0, 0, r2, ed);
    tests++;
    if (r1 !== 32'(a)) begin
      fails++;
      $display("FAIL cycle_abs: got %0d, required %0d", r1, a);
    end
    tests++;
    if (r2 - r1 !== 32'd10) begin
      fails++;
      $display("FAIL cycle_delta: got %0d, required 10", r2 - r1);
    end
  endtask

  task automatic test_exit();
    logic [31:0] rd, exp;
    int ed;
    cpu_access(1, 0, IO_BASE + 32'd12, 32'h0000_0107, 0, rd, ed);
    halt_m = 1; code_m = 8'h07;
    tests++;
    if ({o_halt, o_exit_code} !== {1'b1, 8'h07}) begin
      fails++;
      $display("FAIL exit_first: halt/code=%b/%h, required 1/07", o_halt, o_exit_code);
    end
    cpu_access(1, 0, IO_BASE + 32'd12, 32'h0000_0009, 0, rd, ed);
    tests++;
    if ({o_halt, o_exit_code} !== {halt_m, code_m}) begin
      fails++;
      $display("FAIL exit_second: halt/code=%b/%h, required 1/07", o_halt, o_exit_code);
    end
    cpu_access(0, 0, IO_BASE + 32'd12, 32'h0, 0, rd, ed);
    tests++;
    if (rd !== {24'b0, code_m}) begin
      fails++;
      $display("FAIL exit_read: got %h, required %h", rd, {24'b0, code_m});
    end
    cpu_access(0, 0, IO_BASE + 32'd4, 32'h0, 0, rd, ed);
    tests++;
    if (rd !== 32'h2) begin
      fails++;
      $display("FAIL status_halted: got %h, required 00000002", rd);
    end
    cpu_access(1, 0, IO_BASE + 32'd8, 32'h0, 0, rd, ed);
    exp = 32'(tb_edges);
    cpu_access(0, 0, IO_BASE + 32'd8, 32'h0, 0, rd, ed);
    tests++;
    if (rd !== exp) begin
      fails++;
      $display("FAIL cycle_write_ignored: got %0d, required %0d", rd, exp);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned a;
    logic [31:0] exp;
    a = tb_edges;
    i_addr = IO_BASE + 32'd8;
    i_read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp = (k % 2 == 1) ? 32'(a + k - 1) : 32'h0;
      tests++;
      if ({o_done, o_data_read} !== {1'(k % 2), exp}) begin
        fails++;
        $display("FAIL b2b_edge%0d: done/data=%b/%0d, required %b/%0d",
                 k, o_done, o_data_read, 1'(k % 2), exp);
      end
    end
    i_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int ed;
    int seen;
    ram_silent = 1;
    i_addr = 32'h0000_0200;
    i_read = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (o_ram_read !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_strobe_up: o_ram_read=%b, required 1", o_ram_read);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++;
    if ({o_ram_read, o_done, o_halt} !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_async: ram_read/done/halt=%b, required 000", {o_ram_read, o_done, o_halt});
    end
    i_read = 1'b0;
    halt_m = 0; code_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ram_silent = 0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (o_done || o_ram_read) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rstmid_no_done: %0d cycles with done/strobe, required 0", seen);
    end
    cpu_access(0, 0, 32'h0000_0100, 32'h0, 1, rd, ed);
    tests++;
    if (rd !== ref_read(32'h0000_0100)) begin
      fails++;
      $display("FAIL rstmid_recover: got %h, required %h", rd, ref_read(32'h0000_0100));
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd;
    int ed;
    ram_silent = 1;
    cpu_access(0, 0, 32'h0000_0300, 32'h0, 0, rd, ed);
    ram_silent = 0;
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL timeout_data: got %h, required deadbeef", rd);
    end
    tests++;
    if (ed != int'(TIMEOUT) + 2) begin
      fails++;
      $display("FAIL timeout_latency: got %0d edges, required %0d", ed, TIMEOUT + 2);
    end
    tests++;
    if (o_bus_error !== 1'b1) begin
      fails++;
      $display("FAIL timeout_flag: o_bus_error=%b, required 1", o_bus_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ram_read();
    test_random();
    test_console();
    test_cycle();
    test_exit();
    test_back_to_back();
    test_reset_mid();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`else
    tests++;
    if (o_bus_error !== 1'b0) begin
      fails++;
      $display("FAIL bus_error_tied: o_bus_error=%b, required 0", o_bus_error);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
